// File: rtl/fft_unload_reorder.sv
// fft_unload_reorder: captures FFT result frames (addressed, any order) into a
// ping-pong buffer and streams each frame out in bin order over valid/ready.
//
// Ports:
//   iclk, rst_n        clock, asynchronous active-low reset
//   ien/iaddr/iReal/iImag   sample strobe from the FFT core (no backpressure)
//   ovalid/iready      output handshake
//   oindex/oReal/oImag output bin index and data
//   olast              high with the final sample of a frame
//   oovf               sticky: a sample arrived while both banks were occupied
//
// Optional feature: define FFT_UNLOAD_FFTSHIFT_EN to emit frames DC-centred
// (bins N/2..N-1 then 0..N/2-1); oindex reports the bin actually read.

module fft_unload_reorder #(
    parameter int unsigned TOTAL_STAGE_P = 6,
    parameter int unsigned MULT_WIDTH_P  = 18
) (
    input  logic                     iclk,
    input  logic                     rst_n,
    input  logic                     ien,
    input  logic [TOTAL_STAGE_P-1:0] iaddr,
    input  logic [MULT_WIDTH_P-1:0]  iReal,
    input  logic [MULT_WIDTH_P-1:0]  iImag,
    output logic                     ovalid,
    input  logic                     iready,
    output logic [TOTAL_STAGE_P-1:0] oindex,
    output logic [MULT_WIDTH_P-1:0]  oReal,
    output logic [MULT_WIDTH_P-1:0]  oImag,
    output logic                     olast,
    output logic                     oovf
);

    localparam int unsigned N  = 1 << TOTAL_STAGE_P;
    localparam int unsigned DW = 2 * MULT_WIDTH_P;
    localparam logic [TOTAL_STAGE_P-1:0] LAST_IDX = '1;
`ifdef FFT_UNLOAD_FFTSHIFT_EN
    // MSB only: flips the two halves of the frame
    localparam logic [TOTAL_STAGE_P-1:0] RD_XOR = LAST_IDX ^ (LAST_IDX >> 1);
`else
    localparam logic [TOTAL_STAGE_P-1:0] RD_XOR = '0;
`endif

    typedef enum logic {StIdle, StStream} rd_state_e;

    // Both banks in one array; bank select is the address MSB.
    logic [DW-1:0] mem [2*N];

    // ---------------- write side ----------------
    logic                     wb_q, wb_d;
    logic [TOTAL_STAGE_P-1:0] wcnt_q, wcnt_d;
    logic [1:0]               full_q, full_d;
    logic                     ovf_q, ovf_d;
    logic                     wr_en, wr_done;

    // ---------------- read side ----------------
    rd_state_e                state_q, state_d;
    logic                     rb_q, rb_d;
    logic [TOTAL_STAGE_P-1:0] rptr_q, rptr_d;
    logic                     ovalid_q, ovalid_d;
    logic                     olast_q, olast_d;
    logic [TOTAL_STAGE_P-1:0] oindex_q, oindex_d;
    logic [DW-1:0]            rdata_q;
    logic                     advance, load, rd_done, other_full;
    logic [TOTAL_STAGE_P-1:0] rd_ptr, rd_addr;

    assign wr_en   = ien && !full_q[wb_q];
    assign wr_done = wr_en && (wcnt_q == LAST_IDX);

    always_comb begin
        wb_d   = wb_q;
        wcnt_d = wcnt_q;
        ovf_d  = ovf_q;
        if (ien && full_q[wb_q]) begin
            ovf_d = 1'b1;
        end
        if (wr_en) begin
            // Wraps to 0 on the N-th sample
            wcnt_d = wcnt_q + 1'b1;
            if (wr_done) begin
                wb_d = ~wb_q;
            end
        end
    end

    // Writer and reader always touch different banks here: the writer only
    // completes into a non-full bank, the reader only frees a full one.
    always_comb begin
        full_d = full_q;
        if (wr_done) begin
            full_d[wb_q] = 1'b1;
        end
        if (rd_done) begin
            full_d[rb_q] = 1'b0;
        end
    end

    always_ff @(posedge iclk) begin
        if (wr_en) begin
            mem[{wb_q, iaddr}] <= {iReal, iImag};
        end
    end

    assign advance = !ovalid_q || iready;
    // Pointer is implicitly 0 when a frame starts from idle.
    assign rd_ptr  = (state_q == StIdle) ? '0 : rptr_q;
    assign rd_addr = rd_ptr ^ RD_XOR;
    // Includes a frame completing on this very edge, so streaming stays gapless.
    assign other_full = full_q[~rb_q] || (wr_done && (wb_q != rb_q));

    always_comb begin
        state_d  = state_q;
        rptr_d   = rptr_q;
        rb_d     = rb_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;
        oindex_d = oindex_q;
        load     = 1'b0;
        rd_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (full_q[rb_q]) begin
                    state_d = StStream;
                    rptr_d  = '0;
                    // Load word 0 immediately to save a cycle of latency
                    load    = advance;
                end else if (ovalid_q && iready) begin
                    ovalid_d = 1'b0;
                    olast_d  = 1'b0;
                end
            end
            StStream: begin
                load = advance;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            ovalid_d = 1'b1;
            oindex_d = rd_addr;
            olast_d  = (rd_ptr == LAST_IDX);
            rptr_d   = rd_ptr + 1'b1;
            if (rd_ptr == LAST_IDX) begin
                rd_done = 1'b1;
                rb_d    = ~rb_q;
                state_d = other_full ? StStream : StIdle;
            end
        end
    end

    always_ff @(posedge iclk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q     <= 1'b0;
            wcnt_q   <= '0;
            full_q   <= '0;
            ovf_q    <= 1'b0;
            state_q  <= StIdle;
            rb_q     <= 1'b0;
            rptr_q   <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            oindex_q <= '0;
            rdata_q  <= '0;
        end else begin
            wb_q     <= wb_d;
            wcnt_q   <= wcnt_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            rb_q     <= rb_d;
            rptr_q   <= rptr_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
            oindex_q <= oindex_d;
            if (load) begin
                rdata_q <= mem[{rb_q, rd_addr}];
            end
        end
    end

    assign ovalid = ovalid_q;
    assign olast  = olast_q;
    assign oindex = oindex_q;
    assign oReal  = rdata_q[DW-1:MULT_WIDTH_P];
    assign oImag  = rdata_q[MULT_WIDTH_P-1:0];
    assign oovf   = ovf_q;

endmodule

// File: tb/tb_fft_unload_reorder.sv
// Self-checking bench for fft_unload_reorder (N=64, 18-bit components).
// Expected outputs come from a scoreboard queue filled by the stimulus code.

module tb_fft_unload_reorder;

    localparam int P = 6;
    localparam int W = 18;
    localparam int N = 64;
`ifdef FFT_UNLOAD_FFTSHIFT_EN
    localparam int SHIFT = 32;
`else
    localparam int SHIFT = 0;
`endif

    logic         iclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ien = 1'b0;
    logic [P-1:0] iaddr = '0;
    logic [W-1:0] iReal = '0;
    logic [W-1:0] iImag = '0;
    logic         iready = 1'b1;
    logic         ovalid;
    logic [P-1:0] oindex;
    logic [W-1:0] oReal;
    logic [W-1:0] oImag;
    logic         olast;
    logic         oovf;

    fft_unload_reorder #(
        .TOTAL_STAGE_P (P),
        .MULT_WIDTH_P  (W)
    ) dut (
        .iclk   (iclk),
        .rst_n  (rst_n),
        .ien    (ien),
        .iaddr  (iaddr),
        .iReal  (iReal),
        .iImag  (iImag),
        .ovalid (ovalid),
        .iready (iready),
        .oindex (oindex),
        .oReal  (oReal),
        .oImag  (oImag),
        .olast  (olast),
        .oovf   (oovf)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int idx;
        int re;
        int im;
        int last;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_out    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [P-1:0] bitrev(input int k);
        logic [P-1:0] v;
        logic [P-1:0] r;
        v = P'(k);
        for (int i = 0; i < P; i++) begin
            r[i] = v[P-1-i];
        end
        return r;
    endfunction

    task automatic push_frame(input int tag);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.idx  = k ^ SHIFT;
            e.re   = (tag << 8) | e.idx;
            e.im   = N - e.idx;
            e.last = (k == N - 1) ? 1 : 0;
            q.push_back(e);
        end
    endtask

    // Back-to-back frames; sample k of frame f carries address bitrev(k).
    task automatic send_frames(input int nframes, input int tag0, input int nsamp);
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < nsamp; k++) begin
                @(posedge iclk);
                #1;
                ien   = 1'b1;
                iaddr = bitrev(k);
                iReal = W'(((tag0 + f) << 8) | int'(bitrev(k)));
                iImag = W'(N - int'(bitrev(k)));
            end
        end
        @(posedge iclk);
        #1;
        ien = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (q.size() != 0 && i < budget) begin
            @(posedge iclk);
            i++;
        end
        check("drain_remaining", q.size(), 0);
        @(posedge iclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge iclk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ovalid", ovalid, 0);
        check("rst_olast", olast, 0);
        check("rst_oovf", oovf, 0);
        check("rst_oindex", oindex, 0);
        check("rst_oReal", oReal, 0);
        check("rst_oImag", oImag, 0);
        repeat (2) @(posedge iclk);
        q.delete();
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    logic         stall_q = 1'b0;
    logic [P-1:0] h_idx;
    logic [W-1:0] h_re;
    logic [W-1:0] h_im;
    logic         h_last;

    always @(negedge iclk) begin
        exp_t e;
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", ovalid, 1);
                check("hold_idx", oindex, h_idx);
                check("hold_re", oReal, h_re);
                check("hold_im", oImag, h_im);
                check("hold_last", olast, h_last);
            end
            if (ovalid && iready) begin
                if (q.size() == 0) begin
                    check("extra_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("out_idx", oindex, e.idx);
                    check("out_re", oReal, e.re);
                    check("out_im", oImag, e.im);
                    check("out_last", olast, e.last);
                    n_out++;
                end
            end
            stall_q = ovalid && !iready;
            h_idx   = oindex;
            h_re    = oReal;
            h_im    = oImag;
            h_last  = olast;
        end
    end

    initial begin
        int start_out;
        int i;

        do_reset();

        // 1: bit-reversed fill, natural-order output, one-cycle latency
        iready = 1'b1;
        push_frame(0);
        send_frames(1, 0, N);
        check("lat_not_yet_valid", ovalid, 0);
        @(posedge iclk);
        #1;
        check("lat_valid", ovalid, 1);
        check("lat_first_idx", oindex, SHIFT);
        wait_drain(200);
        check("t1_idle_after", ovalid, 0);

        // 2: backpressure with ready pattern 1,0,0,1
        push_frame(1);
        fork
            send_frames(1, 1, N);
            begin
                for (int c = 0; c < 300; c++) begin
                    @(posedge iclk);
                    #1;
                    iready = ((c % 4) == 0 || (c % 4) == 3);
                end
            end
        join
        iready = 1'b1;
        wait_drain(200);
        check("t2_ovf_clear", oovf, 0);

        // 3: overflow, two frames buffered, third dropped
        iready = 1'b0;
        push_frame(10);
        push_frame(11);
        send_frames(3, 10, N);
        repeat (3) @(posedge iclk);
        #1;
        check("t3_ovf_set", oovf, 1);
        check("t3_stalled_valid", ovalid, 1);
        check("t3_stalled_idx", oindex, SHIFT);
        iready = 1'b1;
        wait_drain(400);
        repeat (2) @(posedge iclk);
        #1;
        check("t3_idle_after", ovalid, 0);
        check("t3_ovf_sticky", oovf, 1);

        // 4: continuous streaming, gapless
        do_reset();
        iready = 1'b1;
        push_frame(20);
        push_frame(21);
        push_frame(22);
        start_out = n_out;
        fork
            send_frames(3, 20, N);
            begin
                i = 0;
                @(negedge iclk);
                while (!ovalid && i < 200) begin
                    @(negedge iclk);
                    i++;
                end
                for (int c = 0; c < 3 * N; c++) begin
                    check("t4_gapless", ovalid, 1);
                    @(negedge iclk);
                end
            end
        join
        wait_drain(100);
        check("t4_count", n_out - start_out, 3 * N);
        check("t4_ovf", oovf, 0);

        // 5: reset mid-frame discards the partial frame
        send_frames(1, 30, 30);
        do_reset();
        push_frame(31);
        start_out = n_out;
        send_frames(1, 31, N);
        wait_drain(200);
        repeat (4) @(posedge iclk);
        #1;
        check("t5_count", n_out - start_out, N);
        check("t5_idle_after", ovalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
